noc_local_ingress_fifo: RTL and testbench
=========================================

// Module: noc_local_ingress_fifo
// PURPOSE
//  Sits between a local node's flit sender and the router local input port.
//  Buffers flits in a first-word-fall-through FIFO and enforces packet framing:
//  packets are header..tail, and orphan flits are dropped.
//  Reports framing errors and counts accepted packets for bench and debug visibility.
// PARAMETERS
//  DEPTH      8                 FIFO entries; power of 2, >=2
//  DATA_W     `Noc_Data_Width   flit width
//  CNT_W      16                width of pkt_cnt (wraps)
// PORTS
//  noc_clk        in   1       single clock; all logic on posedge
//  noc_rst        in   1       synchronous, active-high reset
//  in_valid       in   1       upstream flit valid
//  in_ready       out  1       = !full; valid&ready is a transfer
//  in_flit        in   DATA_W  flit payload
//  in_is_header   in   1       first flit of packet
//  in_is_tail     in   1       last flit (header+tail both set = 1-flit packet)
//  out_valid      out  1       = !empty
//  out_ready      in   1       router local port ready
//  out_flit       out  DATA_W  head-of-FIFO flit
//  out_is_header  out  1       stored header flag
//  out_is_tail    out  1       stored tail flag
//  frame_err      out  1       sticky framing error; cleared only by reset
//  drop_pulse     out  1       one-cycle pulse per dropped flit
//  pkt_cnt        out  CNT_W   headers written to FIFO, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: FIFO empty, so out_valid=0 and in_ready=1.
//   Also reset: out_flit/out_is_header/out_is_tail=0, frame_err=0, drop_pulse=0,
//   pkt_cnt=0, and the framing FSM goes to IDLE.
//  Reset mid-packet discards all stored flits and returns the FSM to IDLE.
//  Latency: a flit accepted at edge N is presented on out_* after edge N (FWFT, 1 cycle).
//  Full: in_ready=0 and upstream holds its flit.
//   Push and pop in the same cycle are allowed when not full; count is unchanged.
//  Empty: out_valid=0 and out_* hold the last value (zero after reset).
//  Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH+1) bits.
//  Framing FSM, evaluated on each in transfer:
//   IDLE, header&!tail : write flit, pkt_cnt++, go to IN_PKT.
//   IDLE, header&tail  : write flit, pkt_cnt++, stay in IDLE.
//   IDLE, !header      : drop flit (not written), drop_pulse=1, frame_err=1.
//   IN_PKT, !header&tail  : write flit, go to IDLE.
//   IN_PKT, !header&!tail : write flit, stay in IN_PKT.
//   IN_PKT, header        : write flit, frame_err=1, pkt_cnt++; the flit starts a
//                           new packet (next state follows in_is_tail as in IDLE).
//   DROP (feature only)   : do not write; drop_pulse=1; go to IDLE on tail.
//  Dropped flits still complete the handshake (in_ready=!full), so upstream never stalls.
// CONFIGURATION
//  NOC_INGRESS_HDR_CHECK_EN defined:
//   A header flit whose [DATA_W-1:`Noc_Point_H] != `Noc_Head_H, or whose
//   [`Axi_Len_Point-1:`Noc_Point_E] != `Noc_Head_E, is dropped.
//   The rest of that packet is also dropped (FSM goes to DROP, or IDLE if the
//   header is also a tail), frame_err is set, and pkt_cnt does not increment.
//  Not defined: header contents are not inspected and the DROP state does not exist.
// STRUCTURE
//  Shared constants (Noc_Head_H/E, Noc_Point_H/E, Axi_Len_Point, Noc_Data_Width)
//   stay in Noc_parameters.v. Add `Noc_Ingress_Depth default there.
//  Sub-module noc_sync_fifo #(WIDTH=DATA_W+2, DEPTH): storage, pointers, full/empty.
//   This top level holds the framing FSM, drop logic and counters.
// TESTING
//  1 Reset, then a 3-flit packet H,D,T with out_ready=1 -> out shows H,D,T on
//    consecutive cycles, 1 cycle after each input; pkt_cnt=1; frame_err=0.
//  2 DEPTH=8, out_ready=0, push 9 flits -> in_ready=0 after the 8th;
//    the 9th is held; raise out_ready -> all 9 emerge in order.
//  3 Data flit with no header in IDLE -> not output; drop_pulse for 1 cycle;
//    frame_err=1 and stays set.
//  4 H,D, then a new H (no tail) -> all written, frame_err=1, pkt_cnt=2.
//  5 Single-flit header+tail, back-to-back x4 with simultaneous push/pop ->
//    pkt_cnt=4; occupancy never exceeds 1.
//  6 (HDR_CHECK_EN) header with corrupted Head_H field followed by D,T ->
//    3 drop pulses, nothing output, pkt_cnt unchanged.
//  7 Reset asserted with 5 flits stored -> next cycle out_valid=0, in_ready=1,
//    pkt_cnt=0.

Source files
------------

// File: rtl/noc_local_ingress_fifo_pkg.sv
// NoC constants and framing FSM states for the local ingress FIFO.
// NOC_INGRESS_HDR_CHECK_EN adds header field checks and the DROP state.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 28
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Axi_Len_Point
`define Axi_Len_Point 8
`endif
`ifndef Noc_Point_E
`define Noc_Point_E 4
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Ingress_Depth
`define Noc_Ingress_Depth 8
`endif

package noc_local_ingress_fifo_pkg;

  localparam int NOC_DATA_W        = `Noc_Data_Width;
  localparam int ING_DEPTH         = `Noc_Ingress_Depth;
  localparam int ING_CNT_W         = 16;
  localparam int NOC_POINT_H       = `Noc_Point_H;
  localparam int NOC_POINT_E       = `Noc_Point_E;
  localparam int NOC_AXI_LEN_POINT = `Axi_Len_Point;

  localparam logic [NOC_DATA_W-NOC_POINT_H-1:0] NOC_HEAD_H =
    `Noc_Head_H;
  localparam logic [NOC_AXI_LEN_POINT-NOC_POINT_E-1:0] NOC_HEAD_E =
    `Noc_Head_E;

`ifdef NOC_INGRESS_HDR_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT,
    ST_DROP
  } frame_st_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_IN_PKT
  } frame_st_e;
`endif

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
// When empty, the read port holds the last word popped (zero after reset).
module noc_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hold;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? r_hold : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_hold <= r_mem[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/noc_local_ingress_fifo.sv
// Local node ingress buffer: FWFT FIFO plus packet framing and drop logic.
// Define NOC_INGRESS_HDR_CHECK_EN to drop packets with malformed headers.
module noc_local_ingress_fifo
  import noc_local_ingress_fifo_pkg::*;
#(
  parameter int DEPTH  = ING_DEPTH,
  parameter int DATA_W = NOC_DATA_W,
  parameter int CNT_W  = ING_CNT_W
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_is_header,
  input  logic              in_is_tail,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_flit,
  output logic              out_is_header,
  output logic              out_is_tail,
  output logic              frame_err,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  pkt_cnt
);

  frame_st_e        r_state;
  logic             r_frame_err;
  logic             r_drop;
  logic [CNT_W-1:0] r_pkt_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_xfer;
  logic              w_keep;
  logic              w_wr;
  logic              w_hdr_ok;
  logic [DATA_W+1:0] w_rdata;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign w_xfer    = in_valid & ~w_full;
  assign w_wr      = w_xfer & w_keep;

  assign out_is_header = w_rdata[DATA_W+1];
  assign out_is_tail   = w_rdata[DATA_W];
  assign out_flit      = w_rdata[DATA_W-1:0];
  assign frame_err     = r_frame_err;
  assign drop_pulse    = r_drop;
  assign pkt_cnt       = r_pkt_cnt;

`ifdef NOC_INGRESS_HDR_CHECK_EN
  assign w_hdr_ok =
    (in_flit[DATA_W-1:NOC_POINT_H] == NOC_HEAD_H) &&
    (in_flit[NOC_AXI_LEN_POINT-1:NOC_POINT_E] == NOC_HEAD_E);
`else
  assign w_hdr_ok = 1'b1;
`endif

  // Only flits the FSM accepts reach the FIFO; drops still handshake.
  always_comb begin
    w_keep = 1'b0;
    unique case (r_state)
      ST_IDLE:   w_keep = in_is_header & w_hdr_ok;
      ST_IN_PKT: w_keep = ~in_is_header | w_hdr_ok;
      default:   w_keep = 1'b0;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state     <= ST_IDLE;
      r_frame_err <= 1'b0;
      r_drop      <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_drop <= 1'b0;
      if (w_xfer) begin
        unique case (r_state)
          ST_IDLE: begin
            if (!in_is_header) begin
              r_drop      <= 1'b1;
              r_frame_err <= 1'b1;
            end else if (w_hdr_ok) begin
              r_pkt_cnt <= r_pkt_cnt + 1'b1;
              r_state   <= in_is_tail ? ST_IDLE : ST_IN_PKT;
`ifdef NOC_INGRESS_HDR_CHECK_EN
            end else begin
              r_drop      <= 1'b1;
              r_frame_err <= 1'b1;
              r_state     <= in_is_tail ? ST_IDLE : ST_DROP;
`endif
            end
          end
          ST_IN_PKT: begin
            if (!in_is_header) begin
              if (in_is_tail) r_state <= ST_IDLE;
            end else begin
              // Header mid-packet: previous packet is truncated
              r_frame_err <= 1'b1;
              if (w_hdr_ok) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
                r_state   <= in_is_tail ? ST_IDLE : ST_IN_PKT;
`ifdef NOC_INGRESS_HDR_CHECK_EN
              end else begin
                r_drop  <= 1'b1;
                r_state <= in_is_tail ? ST_IDLE : ST_DROP;
`endif
              end
            end
          end
`ifdef NOC_INGRESS_HDR_CHECK_EN
          ST_DROP: begin
            r_drop <= 1'b1;
            if (in_is_tail) r_state <= ST_IDLE;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  noc_sync_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (noc_clk),
    .i_rst   (noc_rst),
    .i_push  (w_wr),
    .i_wdata ({in_is_header, in_is_tail, in_flit}),
    .i_pop   (out_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_noc_local_ingress_fifo.sv
// Scoreboard bench for noc_local_ingress_fifo: directed packets,
// monitor pops expected flits whenever the DUT hands one to the router.
module tb_noc_local_ingress_fifo;
  import noc_local_ingress_fifo_pkg::*;

  localparam int DW = NOC_DATA_W;
  localparam int CW = ING_CNT_W;

  logic          noc_clk = 1'b0;
  logic          noc_rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_flit;
  logic          in_is_header;
  logic          in_is_tail;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_flit;
  logic          out_is_header;
  logic          out_is_tail;
  logic          frame_err;
  logic          drop_pulse;
  logic [CW-1:0] pkt_cnt;

  typedef struct {
    logic [DW-1:0] f;
    logic          h;
    logic          t;
  } exp_t;

  exp_t q[$];
  int   vecs  = 0;
  int   errs  = 0;
  int   drops = 0;

  always #5 noc_clk = ~noc_clk;

  noc_local_ingress_fifo dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flit       (in_flit),
    .in_is_header  (in_is_header),
    .in_is_tail    (in_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .frame_err     (frame_err),
    .drop_pulse    (drop_pulse),
    .pkt_cnt       (pkt_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: each handoff to the router is checked against the queue
  always @(negedge noc_clk) begin
    if (!noc_rst) begin
      if (drop_pulse) drops++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {32'h0, out_flit}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_flit", {32'h0, out_flit}, {32'h0, e.f});
          chk("out_hdr", {63'h0, out_is_header}, {63'h0, e.h});
          chk("out_tail", {63'h0, out_is_tail}, {63'h0, e.t});
        end
      end
    end
  end

  function automatic logic [DW-1:0] hf(input logic [15:0] id);
    logic [DW-1:0] f;
    f = '0;
    f[23:8] = id;
    f[DW-1:NOC_POINT_H] = NOC_HEAD_H;
    f[NOC_AXI_LEN_POINT-1:NOC_POINT_E] = NOC_HEAD_E;
    return f;
  endfunction

  function automatic logic [DW-1:0] df(input logic [15:0] id);
    return {16'hD0D0, id};
  endfunction

  task automatic send(input logic [DW-1:0] f, input logic h,
                      input logic t, input bit keep);
    bit ok;
    int n;
    exp_t e;
    if (keep) begin
      e.f = f;
      e.h = h;
      e.t = t;
      q.push_back(e);
    end
    in_valid     = 1'b1;
    in_flit      = f;
    in_is_header = h;
    in_is_tail   = t;
    ok = 1'b0;
    n  = 0;
    do begin
      @(negedge noc_clk);
      ok = in_ready;
      @(posedge noc_clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 64'h0, 64'h1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge noc_clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge noc_clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'h0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    noc_rst  = 1'b1;
    @(posedge noc_clk);
    #1;
    q.delete();
    noc_rst = 1'b0;
  endtask

  initial begin
    int d0;
    noc_rst      = 1'b1;
    in_valid     = 1'b0;
    in_flit      = '0;
    in_is_header = 1'b0;
    in_is_tail   = 1'b0;
    out_ready    = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_out_flit", {32'h0, out_flit}, 64'h0);
    chk("rst_pkt_cnt", {48'h0, pkt_cnt}, 64'h0);
    chk("rst_frame_err", {63'h0, frame_err}, 64'h0);
    chk("rst_drop", {63'h0, drop_pulse}, 64'h0);
    noc_rst = 1'b0;

    // 1: H,D,T flowing through, one cycle latency each
    out_ready = 1'b1;
    send(hf(16'h0101), 1'b1, 1'b0, 1'b1);
    chk("t1_lat_h", {31'h0, out_valid, out_flit}, {31'h0, 1'b1, hf(16'h0101)});
    send(df(16'h0102), 1'b0, 1'b0, 1'b1);
    chk("t1_lat_d", {31'h0, out_valid, out_flit}, {31'h0, 1'b1, df(16'h0102)});
    send(df(16'h0103), 1'b0, 1'b1, 1'b1);
    chk("t1_lat_t", {31'h0, out_valid, out_flit}, {31'h0, 1'b1, df(16'h0103)});
    idle(2);
    drain();
    chk("t1_pkt_cnt", {48'h0, pkt_cnt}, 64'h1);
    chk("t1_frame_err", {63'h0, frame_err}, 64'h0);

    // 2: fill to full, ninth flit held until the router drains
    out_ready = 1'b0;
    send(hf(16'h0201), 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 8; i++) send(df(16'(16'h0200 + i)), 1'b0, 1'b0, 1'b1);
    chk("t2_full", {63'h0, in_ready}, 64'h0);
    in_valid     = 1'b1;
    in_flit      = df(16'h0209);
    in_is_header = 1'b0;
    in_is_tail   = 1'b1;
    repeat (3) @(posedge noc_clk);
    #1;
    chk("t2_held", {63'h0, in_ready}, 64'h0);
    chk("t2_head", {32'h0, out_flit}, {32'h0, hf(16'h0201)});
    out_ready = 1'b1;
    send(df(16'h0209), 1'b0, 1'b1, 1'b1);
    idle(1);
    drain();
    chk("t2_pkt_cnt", {48'h0, pkt_cnt}, 64'h2);
    chk("t2_frame_err", {63'h0, frame_err}, 64'h0);

    // 3: orphan data flit in IDLE is dropped
    d0 = drops;
    send(df(16'h0301), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t3_drops", 64'(drops - d0), 64'h1);
    chk("t3_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t3_frame_err", {63'h0, frame_err}, 64'h1);
    chk("t3_drop_low", {63'h0, drop_pulse}, 64'h0);
    idle(2);
    chk("t3_sticky", {63'h0, frame_err}, 64'h1);

    // 4: header arrives mid-packet
    do_reset();
    chk("t4_rst_err", {63'h0, frame_err}, 64'h0);
    send(hf(16'h0401), 1'b1, 1'b0, 1'b1);
    send(df(16'h0402), 1'b0, 1'b0, 1'b1);
    send(hf(16'h0403), 1'b1, 1'b0, 1'b1);
    send(df(16'h0404), 1'b0, 1'b1, 1'b1);
    idle(2);
    drain();
    chk("t4_frame_err", {63'h0, frame_err}, 64'h1);
    chk("t4_pkt_cnt", {48'h0, pkt_cnt}, 64'h2);

    // 5: back-to-back single-flit packets with push and pop together
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(hf(16'(16'h0500 + i)), 1'b1, 1'b1, 1'b1);
      chk("t5_head", {32'h0, out_flit}, {32'h0, hf(16'(16'h0500 + i))});
    end
    idle(2);
    drain();
    chk("t5_pkt_cnt", {48'h0, pkt_cnt}, 64'h4);
    chk("t5_frame_err", {63'h0, frame_err}, 64'h0);

`ifdef NOC_INGRESS_HDR_CHECK_EN
    // 6: corrupted header drops the whole packet
    do_reset();
    d0 = drops;
    begin
      logic [DW-1:0] bad;
      bad = hf(16'h0601);
      bad[DW-1:NOC_POINT_H] = ~NOC_HEAD_H;
      send(bad, 1'b1, 1'b0, 1'b0);
    end
    send(df(16'h0602), 1'b0, 1'b0, 1'b0);
    send(df(16'h0603), 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t6_drops", 64'(drops - d0), 64'h3);
    chk("t6_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t6_pkt_cnt", {48'h0, pkt_cnt}, 64'h0);
    chk("t6_frame_err", {63'h0, frame_err}, 64'h1);
    send(hf(16'h0604), 1'b1, 1'b1, 1'b1);
    idle(2);
    drain();
    chk("t6_recover", {48'h0, pkt_cnt}, 64'h1);
`endif

    // 7: reset with five flits stored
    do_reset();
    out_ready = 1'b0;
    send(hf(16'h0701), 1'b1, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) send(df(16'(16'h0700 + i)), 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t7_stored", {63'h0, out_valid}, 64'h1);
    noc_rst = 1'b1;
    @(posedge noc_clk);
    #1;
    q.delete();
    chk("t7_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t7_in_ready", {63'h0, in_ready}, 64'h1);
    chk("t7_pkt_cnt", {48'h0, pkt_cnt}, 64'h0);
    chk("t7_out_flit", {32'h0, out_flit}, 64'h0);
    noc_rst   = 1'b0;
    out_ready = 1'b1;
    d0 = drops;
    send(df(16'h0706), 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t7_idle_drop", 64'(drops - d0), 64'h1);
    chk("t7_empty", {63'h0, out_valid}, 64'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
